noc_packet_injector: RTL
========================

NOC_PACKET_INJECTOR -- requirements
Module: noc_packet_injector

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width.
REQ-002 Parameter TYPE_WIDTH, default 2, flit-type field width, located at [DATA_WIDTH-1 -: TYPE_WIDTH].
REQ-003 Parameter DEST_WIDTH, default 3, destination field width, located at head flit bits [DEST_WIDTH-1:0].
REQ-004 Parameter FLITS_PER_PACKET, default 6, flit count including head and tail; legal values 2..255.
REQ-005 Signal list, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a burst.
- dest  in  DEST_WIDTH  burst destination.
- num_packets  in  8  packets per burst.
- gap  in  4  idle cycles between packets.
- inj_data  out  DATA_WIDTH  flit toward router.
- inj_valid  out  1  flit valid.
- inj_ready  in  1  router accepts flit.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.
- pkts_sent  out  8  packets fully sent in the current burst.
- ej_data  in  DATA_WIDTH  flit from router (checker).
- ej_valid  in  1  ejected flit valid.
- ej_ready  out  1  checker accepts flit.
- pkts_rcvd  out  8  well-formed packets received.
- err  out  1  sticky protocol-error flag.

Function
REQ-006 Type encoding: 01 head, 10 body, 11 tail; 00 is illegal on any valid flit.
REQ-007 Head flit: type 01, dest in [DEST_WIDTH-1:0], all other bits zero.
REQ-008 Body/tail flit payload: bits [15:8] = pkts_sent, bits [7:0] = flit index (head = 0), remaining non-type bits zero.
REQ-009 FSM states: IDLE, HEAD, BODY, TAIL, GAP.
REQ-010 IDLE + start: latch dest, num_packets and gap; clear pkts_sent, pkts_rcvd and err; go to HEAD next cycle; busy=1.
REQ-011 A flit is transferred only on a cycle with inj_valid=1 and inj_ready=1; inj_data stays stable while inj_valid=1 and inj_ready=0.
REQ-012 Transitions:
- HEAD -> BODY on transfer, or -> TAIL when FLITS_PER_PACKET=2.
- BODY -> TAIL on the transfer of flit index FLITS_PER_PACKET-2.
- TAIL transfer: pkts_sent increments.
- If pkts_sent reaches num_packets: go to IDLE and pulse done.
- Otherwise: go to GAP if gap>0, else go to HEAD.
REQ-013 GAP holds inj_valid=0 for exactly gap cycles, then enters HEAD.
REQ-014 inj_valid=1 in HEAD, BODY and TAIL only; throughput is one flit per cycle when inj_ready is held at 1.
REQ-015 num_packets=0: the burst emits no flits; done pulses on the cycle after start; FSM returns to IDLE.
REQ-016 start while busy=1 is ignored; latched values are unchanged.
REQ-017 pkts_sent and pkts_rcvd saturate at 255.

Reset
REQ-018 rst low asynchronously forces:
- FSM to IDLE.
- inj_valid=0, inj_data=0, busy=0, done=0.
- pkts_sent=0, pkts_rcvd=0, err=0.
- ej_ready=0.
REQ-019 Reset mid-packet abandons the packet; no tail is emitted after reset release.
REQ-020 ej_ready rises to 1 on the first clock edge after rst is released.

Configuration
REQ-021 Macro NOC_INJ_CHECKER_EN.
- Defined: the ejection checker is compiled in; ej_ready=1 after reset.
  - Checker tracks in-packet state and flit count.
  - err is set on: body or tail with no open packet; head inside an open packet; type 00 while ej_valid=1; tail whose packet count differs from FLITS_PER_PACKET.
  - pkts_rcvd increments on each correct tail.
- Undefined: no checker logic; ej_ready=1 after reset; pkts_rcvd=0 and err=0 constantly.

Verification
REQ-022 Required directed scenarios:
- dest=5, num_packets=1, gap=0, inj_ready=1 -> flits 0x40000005, 0x80000001, 0x80000002, 0x80000003, 0x80000004, 0xC0000005 on consecutive cycles; done one cycle after the tail.
- num_packets=3, gap=2 -> exactly 2 idle cycles between each tail and the next head; pkts_sent=3 at done.
- inj_ready toggled every cycle -> each flit is held stable until accepted; 6 accepted flits per packet; no duplicates.
- num_packets=0 -> no inj_valid; done on the cycle after start.
- rst asserted during BODY -> all outputs reach reset values immediately; a new start produces a clean head.
- Checker defined, inj looped to ej, num_packets=4 -> pkts_rcvd=4, err=0.
- Checker defined, tail injected with no head -> err=1, held until the next start.

Source files
------------

// File: rtl/noc_packet_injector.sv
// noc_packet_injector
//   Traffic generator plus optional ejection checker for a NoC router port.
//   On start it injects a burst of num_packets packets of FLITS_PER_PACKET
//   flits each (head, body..., tail) toward dest. It inserts gap idle cycles
//   between packets and pulses done when the burst completes.
//
//   Optional feature: define NOC_INJ_CHECKER_EN to compile in the ejection
//   checker. The checker validates packet framing on ej_*, counts good
//   packets in pkts_rcvd and raises the sticky err flag. Without the macro,
//   pkts_rcvd and err are constant zero.
//
// Ports
//   clk, rst (async, active-low)
//   start/dest/num_packets/gap  burst request and its parameters
//   inj_data/inj_valid/inj_ready  injection flit channel (valid/ready)
//   busy, done, pkts_sent       burst status
//   ej_data/ej_valid/ej_ready   ejection flit channel into the checker
//   pkts_rcvd, err              checker results
module noc_packet_injector #(
   parameter int DATA_WIDTH       = 32,
   parameter int TYPE_WIDTH       = 2,
   parameter int DEST_WIDTH       = 3,
   parameter int FLITS_PER_PACKET = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DEST_WIDTH-1:0] dest,
   input  logic [7:0]            num_packets,
   input  logic [3:0]            gap,
   output logic [DATA_WIDTH-1:0] inj_data,
   output logic                  inj_valid,
   input  logic                  inj_ready,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            pkts_sent,
   input  logic [DATA_WIDTH-1:0] ej_data,
   input  logic                  ej_valid,
   output logic                  ej_ready,
   output logic [7:0]            pkts_rcvd,
   output logic                  err
);

   typedef enum logic [2:0] {IDLE, HEAD, BODY, TAIL, GAP} state_t;

   localparam logic [TYPE_WIDTH-1:0] T_HEAD   = TYPE_WIDTH'(1);
   localparam logic [TYPE_WIDTH-1:0] T_BODY   = TYPE_WIDTH'(2);
   localparam logic [TYPE_WIDTH-1:0] T_TAIL   = TYPE_WIDTH'(3);
   localparam logic [7:0]            PRE_TAIL = 8'(FLITS_PER_PACKET - 2);

   state_t                state_q, state_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d;
   logic [7:0]            num_q, num_d;
   logic [3:0]            gap_q, gap_d;
   logic [3:0]            gap_cnt_q, gap_cnt_d;
   logic [7:0]            idx_q, idx_d;
   logic [7:0]            pkts_sent_q, pkts_sent_d;
   logic                  inj_valid_q, inj_valid_d;
   logic [DATA_WIDTH-1:0] inj_data_q, inj_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ej_ready_q, ej_ready_d;
   logic                  xfer;
   logic                  clr;

   always_comb begin
      state_d     = state_q;
      dest_d      = dest_q;
      num_d       = num_q;
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
      idx_d       = idx_q;
      pkts_sent_d = pkts_sent_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ej_ready_d  = 1'b1;
      clr         = 1'b0;
      xfer        = inj_valid_q & inj_ready;

      case (state_q)
         IDLE: begin
            if (start) begin
               clr         = 1'b1;
               dest_d      = dest;
               num_d       = num_packets;
               gap_d       = gap;
               pkts_sent_d = '0;
               idx_d       = '0;
               if (num_packets == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = HEAD;
                  busy_d  = 1'b1;
               end
            end
         end
         HEAD: begin
            if (xfer) begin
               idx_d   = 8'd1;
               state_d = (FLITS_PER_PACKET == 2) ? TAIL : BODY;
            end
         end
         BODY: begin
            if (xfer) begin
               idx_d = idx_q + 8'd1;
               if (idx_q == PRE_TAIL) state_d = TAIL;
            end
         end
         TAIL: begin
            if (xfer) begin
               pkts_sent_d = (pkts_sent_q == 8'hFF) ? pkts_sent_q : pkts_sent_q + 8'd1;
               idx_d       = '0;
               if (pkts_sent_d == num_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (gap_q != '0) begin
                  state_d   = GAP;
                  gap_cnt_d = gap_q;
               end else begin
                  state_d = HEAD;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == 4'd1) state_d = HEAD;
            else gap_cnt_d = gap_cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are built from the next state so they are registered yet
      // line up with the state; a stalled flit keeps identical inputs here.
      inj_valid_d = (state_d == HEAD) || (state_d == BODY) || (state_d == TAIL);
      inj_data_d  = '0;
      case (state_d)
         HEAD: begin
            inj_data_d[DATA_WIDTH-1 -: TYPE_WIDTH] = T_HEAD;
            inj_data_d[DEST_WIDTH-1:0]             = dest_d;
         end
         BODY, TAIL: begin
            inj_data_d[DATA_WIDTH-1 -: TYPE_WIDTH] = (state_d == TAIL) ? T_TAIL : T_BODY;
            inj_data_d[15:8]                       = pkts_sent_d;
            inj_data_d[7:0]                        = idx_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         dest_q      <= '0;
         num_q       <= '0;
         gap_q       <= '0;
         gap_cnt_q   <= '0;
         idx_q       <= '0;
         pkts_sent_q <= '0;
         inj_valid_q <= 1'b0;
         inj_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ej_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         dest_q      <= dest_d;
         num_q       <= num_d;
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
         idx_q       <= idx_d;
         pkts_sent_q <= pkts_sent_d;
         inj_valid_q <= inj_valid_d;
         inj_data_q  <= inj_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ej_ready_q  <= ej_ready_d;
      end
   end

   assign inj_data  = inj_data_q;
   assign inj_valid = inj_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pkts_sent = pkts_sent_q;
   assign ej_ready  = ej_ready_q;

   // Only the type field of ej_data is inspected.
   logic ej_unused;
   assign ej_unused = ^{ej_data, ej_valid};

`ifdef NOC_INJ_CHECKER_EN
   logic [7:0]            pkts_rcvd_q, pkts_rcvd_d;
   logic                  err_q, err_d;
   logic                  in_pkt_q, in_pkt_d;
   logic [7:0]            ej_cnt_q, ej_cnt_d;
   logic [TYPE_WIDTH-1:0] ej_type;

   assign ej_type = ej_data[DATA_WIDTH-1 -: TYPE_WIDTH];

   always_comb begin
      pkts_rcvd_d = pkts_rcvd_q;
      err_d       = err_q;
      in_pkt_d    = in_pkt_q;
      ej_cnt_d    = ej_cnt_q;
      if (ej_valid && ej_ready_q) begin
         case (ej_type)
            T_HEAD: begin
               // A stray head is flagged, and a fresh packet count starts with it.
               if (in_pkt_q) err_d = 1'b1;
               in_pkt_d = 1'b1;
               ej_cnt_d = 8'd1;
            end
            T_BODY: begin
               if (!in_pkt_q) err_d = 1'b1;
               else if (ej_cnt_q != 8'hFF) ej_cnt_d = ej_cnt_q + 8'd1;
            end
            T_TAIL: begin
               if (!in_pkt_q) err_d = 1'b1;
               else if ({1'b0, ej_cnt_q} + 9'd1 != 9'(FLITS_PER_PACKET)) err_d = 1'b1;
               else if (pkts_rcvd_q != 8'hFF) pkts_rcvd_d = pkts_rcvd_q + 8'd1;
               in_pkt_d = 1'b0;
            end
            default: err_d = 1'b1;
         endcase
      end
      if (clr) begin
         pkts_rcvd_d = '0;
         err_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkts_rcvd_q <= '0;
         err_q       <= 1'b0;
         in_pkt_q    <= 1'b0;
         ej_cnt_q    <= '0;
      end else begin
         pkts_rcvd_q <= pkts_rcvd_d;
         err_q       <= err_d;
         in_pkt_q    <= in_pkt_d;
         ej_cnt_q    <= ej_cnt_d;
      end
   end

   assign pkts_rcvd = pkts_rcvd_q;
   assign err       = err_q;
`else
   assign pkts_rcvd = '0;
   assign err       = 1'b0;
`endif

endmodule
